// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: permutation tables, per-round rotation
// amounts and FSM state encoding.
package des_pkg;

  // Entry j holds the 1-based source bit (bit 1 = MSB) for output bit j+1.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFT_SCHEDULE [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GEN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/des_pc1_permutation.sv
// PC-1: selects the 56 non-parity key bits into the C||D order.
module des_pc1_permutation
  import des_pkg::*;
(
  input  logic [1:64] key_i,
  output logic [1:56] cd_o
);

  for (genvar j = 1; j <= 56; j++) begin : g_bit
    assign cd_o[j] = key_i[PC1_TAB[j-1]];
  end

  // Parity bits are dropped by the table.
  logic unused_parity;
  assign unused_parity = ^{key_i[8], key_i[16], key_i[24], key_i[32],
                           key_i[40], key_i[48], key_i[56], key_i[64]};

endmodule

// File: rtl/des_pc2_permutation.sv
// PC-2: compresses the rotated C||D pair into one 48-bit round key.
module des_pc2_permutation
  import des_pkg::*;
(
  input  logic [1:56] cd_i,
  output logic [1:48] rk_o
);

  for (genvar j = 1; j <= 48; j++) begin : g_bit
    assign rk_o[j] = cd_i[PC2_TAB[j-1]];
  end

  // The eight positions PC-2 discards.
  logic unused_drop;
  assign unused_drop = ^{cd_i[9], cd_i[18], cd_i[22], cd_i[25],
                         cd_i[35], cd_i[38], cd_i[43], cd_i[54]};

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one round key per cycle into a packed 16-slot
// bus, forward order for encryption or reversed for decryption.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16,
  parameter int KEY_W      = 48
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [1:64]                   key,
  input  logic                          decrypt,
  output logic                          busy,
  output logic                          done,
  output logic [1:NUM_ROUNDS*KEY_W]     round_keys
);

  state_e                      state_q;
  logic [1:28]                 c_q, d_q, c_d, d_d;
  logic [3:0]                  cnt_q, slot;
  logic                        mode_q, busy_q, done_q;
  logic [1:NUM_ROUNDS*KEY_W]   keys_q;
  logic [1:56]                 pc1_out;
  logic [1:KEY_W]              rk;

  des_pc1_permutation u_pc1 (.key_i(key), .cd_o(pc1_out));
  des_pc2_permutation u_pc2 (.cd_i({c_d, d_d}), .rk_o(rk));

  always_comb begin
    c_d = {c_q[2:28], c_q[1]};
    d_d = {d_q[2:28], d_q[1]};
    if (SHIFT_SCHEDULE[cnt_q] == 2'd2) begin
      c_d = {c_q[3:28], c_q[1:2]};
      d_d = {d_q[3:28], d_q[1:2]};
    end
    // Decrypt fills slots from the top so K16 lands in slot 1.
    slot = mode_q ? (4'd15 - cnt_q) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      keys_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            c_q     <= pc1_out[1:28];
            d_q     <= pc1_out[29:56];
            cnt_q   <= '0;
            mode_q  <= decrypt;
            busy_q  <= 1'b1;
            state_q <= ST_GEN;
          end
        end
        ST_GEN: begin
          c_q <= c_d;
          d_q <= d_d;
          keys_q[int'(slot)*KEY_W+1 +: KEY_W] <= rk;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign round_keys = keys_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed + random checks of des_key_schedule against a table-driven
// reference computed from cumulative rotation amounts.
module tb_des_key_schedule;

  logic         clk = 1'b0;
  logic         rst, start, decrypt;
  logic [1:64]  key;
  logic         busy, done;
  logic [1:768] round_keys;

  int errors = 0;
  int checks = 0;
  int overlap = 0;
  logic [1:768] snap_gen1;

  des_key_schedule dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .decrypt(decrypt),
    .busy(busy), .done(done), .round_keys(round_keys)
  );

  always #5 clk = ~clk;

  localparam int RPC1 [56] = '{
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
    19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
    14,6,61,53,45,37,29, 21,13,5,28,20,12,4 };
  localparam int RPC2 [48] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32 };

  localparam logic [1:64] KV = 64'h133457799BBCDFF1;

  function automatic logic [1:768] model(logic [1:64] k, bit dec);
    logic [1:56]  cd0, cd;
    logic [1:48]  sk;
    logic [1:768] res;
    int r, slot;
    res = '0;
    r = 0;
    for (int j = 1; j <= 56; j++) cd0[j] = k[RPC1[j-1]];
    for (int i = 1; i <= 16; i++) begin
      r += (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
      for (int j = 1; j <= 28; j++) begin
        cd[j]      = cd0[((j - 1 + r) % 28) + 1];
        cd[28 + j] = cd0[28 + ((j - 1 + r) % 28) + 1];
      end
      for (int b = 1; b <= 48; b++) sk[b] = cd[RPC2[b-1]];
      slot = dec ? 17 - i : i;
      res[48*(slot-1)+1 +: 48] = sk;
    end
    return res;
  endfunction

  function automatic logic [1:768] rev_slots(logic [1:768] v);
    logic [1:768] o;
    for (int s = 0; s < 16; s++) o[48*s+1 +: 48] = v[48*(15-s)+1 +: 48];
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(string tag, logic [1:768] obs, logic [1:768] exp);
    int s;
    s = 0;
    for (int i = 15; i >= 0; i--)
      if (obs[48*i+1 +: 48] !== exp[48*i+1 +: 48]) s = i + 1;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: slot %0d got %h expected %h", tag, s,
             obs[48*(s-1)+1 +: 48], exp[48*(s-1)+1 +: 48]);
    end
  endtask

  // Pulse start, then run until done or a 40-cycle budget; lat = -1 on timeout.
  task automatic go(logic [1:64] k, logic d, output int lat, output int busy_n);
    key = k; decrypt = d; start = 1'b1;
    lat = -1; busy_n = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 1) begin start = 1'b0; snap_gen1 = round_keys; end
      if (busy) busy_n++;
      if (busy && done) overlap++;
      if (done) begin lat = n; break; end
    end
  endtask

  initial begin
    int lat, bn, dones;
    logic [1:768] enc, first;
    logic [1:64] rk;
    logic rd;

    rst = 1'b1; start = 1'b0; key = '0; decrypt = 1'b0;
    tick(); tick();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk_bus("reset_keys", round_keys, '0);
    rst = 1'b0;
    tick();

    // Known encrypt vector
    go(KV, 1'b0, lat, bn);
    chk("enc_latency", 64'(lat), 64'd17);
    chk("enc_busy_cycles", 64'(bn), 64'd16);
    chk("enc_k1", 64'(round_keys[1:48]), 64'h1B02EFFC7072);
    chk("enc_k2", 64'(round_keys[49:96]), 64'h79AED9DBC9E5);
    chk("enc_k16", 64'(round_keys[721:768]), 64'hCB3D8B0E17F5);
    chk_bus("enc_model", round_keys, model(KV, 1'b0));
    enc = round_keys;
    tick();
    chk("done_one_cycle", 64'({busy, done}), 64'd0);
    chk_bus("held_after_done", round_keys, enc);

    // Decrypt order
    go(KV, 1'b1, lat, bn);
    chk("dec_latency", 64'(lat), 64'd17);
    chk("dec_slot1", 64'(round_keys[1:48]), 64'hCB3D8B0E17F5);
    chk("dec_slot16", 64'(round_keys[721:768]), 64'h1B02EFFC7072);
    chk_bus("dec_reversed", round_keys, rev_slots(enc));
    tick();

    // Weak keys with parity bits set
    go(64'h0101010101010101, 1'b0, lat, bn);
    chk_bus("weak_zero", round_keys, '0);
    tick();
    go(64'hFEFEFEFEFEFEFEFE, 1'b0, lat, bn);
    chk_bus("weak_ones", round_keys, '1);
    tick();

    // Start while busy is ignored
    key = KV; decrypt = 1'b0; start = 1'b1; dones = 0; lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 1) start = 1'b0;
      if (n == 5) begin start = 1'b1; key = '0; end
      if (n == 6) start = 1'b0;
      if (busy && done) overlap++;
      if (done) begin dones++; lat = n; end
    end
    chk("busy_start_dones", 64'(dones), 64'd1);
    chk("busy_start_latency", 64'(lat), 64'd17);
    chk_bus("busy_start_keys", round_keys, enc);

    // Reset mid-generation
    key = 64'h0F1571C947D9E859; decrypt = 1'b0; start = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 1) start = 1'b0;
    end
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk_bus("rst_mid_keys", round_keys, '0);
    dones = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (done) dones++;
    end
    chk("rst_no_done", 64'(dones), 64'd0);
    go(KV, 1'b0, lat, bn);
    chk_bus("after_rst_keys", round_keys, enc);
    tick();

    // Back-to-back: second start in the first IDLE cycle after done
    go(KV, 1'b1, lat, bn);
    first = round_keys;
    chk_bus("b2b_finish_hold", first, rev_slots(enc));
    tick();
    go(64'hA5A5F00F3C3C9669, 1'b0, lat, bn);
    chk("b2b_gap", 64'(lat + 1), 64'd18);
    chk_bus("b2b_gen1_hold", snap_gen1, first);
    chk_bus("b2b_second", round_keys, model(64'hA5A5F00F3C3C9669, 1'b0));
    tick();

    // Random keys and directions
    for (int t = 0; t < 8; t++) begin
      rk = {$urandom, $urandom};
      rd = 1'($urandom_range(0, 1));
      go(rk, rd, lat, bn);
      chk("rand_latency", 64'(lat), 64'd17);
      chk_bus("rand_keys", round_keys, model(rk, rd));
      tick();
    end

    chk("busy_done_overlap", 64'(overlap), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
